// File: rtl/therm_pkg.sv
// Shared types and helpers for the thermometer-to-binary encoder.
// s1_t is the bubble-corrected stage-1 payload; the decoder bench can reuse it.
package therm_pkg;

   localparam int unsigned THERM_N = 8;
   localparam int unsigned THERM_W = 2**THERM_N;

   typedef struct packed {
      logic [THERM_W-1:0] c;
      logic               bubble;
      logic               mono_err;
   } s1_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/therm_popcount.sv
// Combinational population count of a 2**N-bit word, N+1 bits wide so all-ones fits.
module therm_popcount #(
   parameter int unsigned N = 8
) (
   input  logic [2**N-1:0] bits_i,
   output logic [N:0]      count_o
);

   localparam int unsigned W = 2**N;

   logic [N:0] sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < W; i++) begin
         sum = sum + (N+1)'(bits_i[i]);
      end
      count_o = sum;
   end

endmodule

// File: rtl/therm_to_bin_encoder.sv
// Thermometer-to-binary encoder: 3-tap bubble correction, popcount encode, malformed-code
// flagging and a saturating error counter behind a two-stage valid/ready pipeline.
module therm_to_bin_encoder
   import therm_pkg::*;
#(
   parameter int unsigned N         = THERM_N,  // S1 payload width comes from therm_pkg
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [2**N-1:0]      therm_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [N-1:0]         dout_o,
   output logic                 bubble_o,
   output logic                 code_err_o,
   output logic [ERR_CNT_W-1:0] err_count_o
);

   localparam int unsigned W = 2**N;
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   logic [W+1:0]         ext;
   s1_t                  s1_d, s1_q;
   logic                 s1_valid_d, s1_valid_q;
   logic                 out_valid_d, out_valid_q;
   logic [N-1:0]         dout_d, dout_q;
   logic                 bubble_d, bubble_q;
   logic                 code_err_d, code_err_q;
   logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
   logic [N:0]           cnt;
   logic                 s2_load, out_xfer, in_xfer;

   // Bubble correction with t[-1]=1 and t[W]=0 supplied by the padded word
   always_comb begin
      s1_d = '0;
      ext  = {1'b0, therm_i, 1'b1};
      for (int i = 0; i < W; i++) begin
         s1_d.c[i] = majority3(ext[i], ext[i+1], ext[i+2]);
      end
      s1_d.bubble   = (s1_d.c != therm_i);
      s1_d.mono_err = |(~s1_d.c[W-2:0] & s1_d.c[W-1:1]);
   end

   therm_popcount #(.N(N)) u_popcount (
      .bits_i  (s1_q.c),
      .count_o (cnt)
   );

   // Handshake control and next-state for both stages and the error counter
   always_comb begin
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      bubble_d    = bubble_q;
      code_err_d  = code_err_q;
      err_cnt_d   = err_cnt_q;

      s2_load    = ~out_valid_q | out_ready_i;
      out_xfer   = out_valid_q & out_ready_i;
      in_ready_o = ~s1_valid_q | s2_load;
      in_xfer    = in_valid_i & in_ready_o;

      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            bubble_d = s1_q.bubble;
            if (cnt == '0) begin
               dout_d     = '0;
               code_err_d = 1'b1;
            end else begin
               dout_d     = N'(cnt - (N+1)'(1));
               code_err_d = s1_q.mono_err;
            end
         end
      end

      if (in_ready_o) begin
         s1_valid_d = in_valid_i;
      end

      if (out_xfer && code_err_q && (err_cnt_q != ERR_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         bubble_q    <= 1'b0;
         code_err_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         if (in_xfer) begin
            s1_q <= s1_d;
         end
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         bubble_q    <= bubble_d;
         code_err_q  <= code_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign dout_o      = dout_q;
   assign bubble_o    = bubble_q;
   assign code_err_o  = code_err_q;
   assign err_count_o = err_cnt_q;

endmodule

// File: doc/therm_to_bin_encoder.md
Name: therm_to_bin_encoder

Overview:
- Downstream consumer of the binary-to-thermometer decoder.
- Accepts a 2**N-bit thermometer word in the decoder's format: value k sets bits [k:0].
- Applies 3-tap bubble correction, encodes the word back to an N-bit binary value, and flags malformed codes.
- Two-stage valid/ready pipeline with full backpressure, plus a saturating error counter for loopback checking of the decoder.

Parameters:
- N, 8, binary width; thermometer width W = 2**N.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle.
- therm  in  W  thermometer word; bit0 always set in a legal code.
- out_valid  out  1  dout and flags valid.
- out_ready  in  1  downstream accepts this cycle.
- dout  out  N  encoded binary value.
- bubble  out  1  input needed correction (qualified by out_valid).
- code_err  out  1  uncorrectable code or all-zero input (qualified by out_valid).
- err_count  out  ERR_CNT_W  count of accepted words with code_err=1; saturates at all-ones.

Behaviour:
- Reset values: in_ready=1, out_valid=0, dout=0, bubble=0, code_err=0, err_count=0. Both pipeline stages are emptied.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Stage 1 (S1), registered on input transfer:
  - Computes corrected bit c[i] = majority(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[W]=0.
  - bubble = (c != therm).
  - mono_err = 1 if c contains any i with c[i]=0 and c[i+1]=1.
- Stage 2 (S2), registered from S1:
  - cnt = popcount(c), width N+1.
  - If cnt==0: dout=0, code_err=1.
  - Else: dout = cnt-1 truncated to N bits, code_err = mono_err.
  - Example: therm with bits [5:0] set gives dout=5. All ones gives dout=W-1.
- Latency: 2 cycles from input transfer to out_valid when no backpressure.
- Throughput: 1 word/cycle.
- Backpressure and stage rules:
  - S2 loads when S2 is empty or an output transfer occurs this cycle.
  - S1 advances into S2 under the same condition.
  - in_ready = (S1 empty) | (S1 advances this cycle). It is combinational from out_ready; no skid buffer.
  - With out_ready=0 and both stages full, in_ready=0. dout and the flags hold stable and out_valid stays 1.
  - Simultaneous input and output transfer in the same cycle: both stages shift, no bubble inserted, no word lost or duplicated.
- err_count:
  - Increments on an output transfer with code_err=1.
  - Holds at 2**ERR_CNT_W-1 once saturated.
  - Unaffected by stalls.
- Reset mid-operation: in-flight words are discarded and err_count clears. Output is available no earlier than 2 cycles after the first post-reset input transfer.
- therm is don't-care when in_valid=0. S1/S2 data registers may hold stale values, but flags are only meaningful with out_valid=1.

Decomposition:
- Shared package therm_pkg holds:
  - localparam W = 2**N helpers.
  - function majority3.
  - typedef struct s1_t {c, bubble, mono_err}, which the decoder bench can reuse.
- Sub-module therm_popcount: combinational W-bit popcount producing N+1 bits, instantiated in S2. It is a natural split for synthesis timing and unit test.
- The handshake pipeline control stays in the top.

Test Plan:
- Clean sweep: drive in_valid=1, out_ready=1 with decoder outputs for k=0..255 back-to-back.
  - Required: dout=k two cycles later, bubble=0, code_err=0, 256 outputs in 256 consecutive cycles.
- Single bubble: therm = bits [9:0] set except bit4 clear.
  - Required: dout=9, bubble=1, code_err=0.
- Uncorrectable and zero codes:
  - therm=0 gives code_err=1, dout=0.
  - therm = bits [3:0] plus bits [20:16] set gives code_err=1.
  - After both, err_count=2.
- Backpressure: stream k=10,11,12,13 while holding out_ready=0 for 5 cycles.
  - Required: in_ready drops after 2 accepts, dout holds 10, then outputs 10..13 in order with no loss.
- Saturation: force ERR_CNT_W=2, send 5 all-zero words.
  - Required: err_count goes 1,2,3,3,3.
- Mid-stream reset: assert reset for 1 cycle with both stages full.
  - Required: out_valid=0, err_count=0, and in_ready=1 the cycle after reset.
